// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player controller.
package maze_pkg;

    localparam int unsigned MOVE_CNT_W = 10;
    localparam int unsigned TILE_W     = 2;

    typedef enum logic [1:0] {
        PATH = 2'b00,
        WALL = 2'b01,
        EXIT = 2'b10,
        RSVD = 2'b11
    } tile_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CHECK = 2'd2,
        WON   = 2'd3
    } pstate_t;

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Button, ROM and display signals of the maze player controller.
interface maze_player_ctrl_if #(
    parameter int unsigned RBITS = 4,
    parameter int unsigned CBITS = 4,
    parameter int unsigned ABITS = 8
);
    logic                            i_up;
    logic                            i_down;
    logic                            i_left;
    logic                            i_right;
    logic [ABITS-1:0]                o_rom_addr;
    logic [maze_pkg::TILE_W-1:0]     i_rom_data;
    logic [RBITS-1:0]                o_row;
    logic [CBITS-1:0]                o_col;
    logic                            o_moved;
    logic                            o_blocked;
    logic                            o_busy;
    logic                            o_win;
    logic [maze_pkg::MOVE_CNT_W-1:0] o_move_count;

    modport master (
        input  i_up, i_down, i_left, i_right, i_rom_data,
        output o_rom_addr, o_row, o_col, o_moved, o_blocked, o_busy, o_win, o_move_count
    );

    modport slave (
        output i_up, i_down, i_left, i_right, i_rom_data,
        input  o_rom_addr, o_row, o_col, o_moved, o_blocked, o_busy, o_win, o_move_count
    );
endinterface

// File: rtl/maze_player_ctrl_move_target_calc.sv
// Combinational direction arbitration (up > down > left > right) and target tile computation.
module move_target_calc
    import maze_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned RBITS = $clog2(ROWS),
    parameter int unsigned CBITS = $clog2(COLS),
    parameter int unsigned ABITS = $clog2(ROWS*COLS)
) (
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_left,
    input  logic             i_right,
    input  logic [RBITS-1:0] i_row,
    input  logic [CBITS-1:0] i_col,
    output logic             o_valid,
    output logic             o_in_bounds,
    output logic [RBITS-1:0] o_tgt_row,
    output logic [CBITS-1:0] o_tgt_col,
    output logic [ABITS-1:0] o_tgt_addr
);

    localparam logic [RBITS-1:0] LAST_ROW = RBITS'(ROWS - 1);
    localparam logic [CBITS-1:0] LAST_COL = CBITS'(COLS - 1);

    dir_t dir;

    always_comb begin
        o_valid = i_up | i_down | i_left | i_right;
        if (i_up)        dir = UP;
        else if (i_down) dir = DOWN;
        else if (i_left) dir = LEFT;
        else             dir = RIGHT;
    end

    // Edges never wrap: the target is only meaningful when o_in_bounds is set.
    always_comb begin
        o_tgt_row   = i_row;
        o_tgt_col   = i_col;
        o_in_bounds = 1'b0;
        case (dir)
            UP: begin
                o_in_bounds = (i_row != '0);
                o_tgt_row   = i_row - RBITS'(1);
            end
            DOWN: begin
                o_in_bounds = (i_row != LAST_ROW);
                o_tgt_row   = i_row + RBITS'(1);
            end
            LEFT: begin
                o_in_bounds = (i_col != '0);
                o_tgt_col   = i_col - CBITS'(1);
            end
            default: begin
                o_in_bounds = (i_col != LAST_COL);
                o_tgt_col   = i_col + CBITS'(1);
            end
        endcase
    end

    assign o_tgt_addr = ABITS'(ABITS'(o_tgt_row) * ABITS'(COLS)) + ABITS'(o_tgt_col);

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player FSM: arbitrates button pulses, checks the target tile in the ROM, updates position.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned ROWS      = 16,
    parameter int unsigned COLS      = 16,
    parameter int unsigned START_ROW = 0,
    parameter int unsigned START_COL = 0,
    parameter int unsigned RBITS     = $clog2(ROWS),
    parameter int unsigned CBITS     = $clog2(COLS),
    parameter int unsigned ABITS     = $clog2(ROWS*COLS)
) (
    input  logic               clk,
    input  logic               rst,
    maze_player_ctrl_if.master bus
);

    localparam logic [RBITS-1:0] START_R    = RBITS'(START_ROW);
    localparam logic [CBITS-1:0] START_C    = CBITS'(START_COL);
    localparam logic [ABITS-1:0] START_ADDR = ABITS'(START_ROW * COLS + START_COL);

    pstate_t                state_q,   state_d;
    logic [RBITS-1:0]       row_q,     row_d;
    logic [CBITS-1:0]       col_q,     col_d;
    logic [RBITS-1:0]       tgt_row_q, tgt_row_d;
    logic [CBITS-1:0]       tgt_col_q, tgt_col_d;
    logic [ABITS-1:0]       addr_q,    addr_d;
    logic [MOVE_CNT_W-1:0]  cnt_q,     cnt_d;
    logic                   moved_q,   moved_d;
    logic                   blocked_q, blocked_d;
    logic                   busy_q,    busy_d;
    logic                   win_q,     win_d;

    logic                   mv_valid;
    logic                   mv_inb;
    logic [RBITS-1:0]       mv_row;
    logic [CBITS-1:0]       mv_col;
    logic [ABITS-1:0]       mv_addr;
    tile_t                  tile;

    move_target_calc #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .RBITS (RBITS),
        .CBITS (CBITS),
        .ABITS (ABITS)
    ) u_calc (
        .i_up        (bus.i_up),
        .i_down      (bus.i_down),
        .i_left      (bus.i_left),
        .i_right     (bus.i_right),
        .i_row       (row_q),
        .i_col       (col_q),
        .o_valid     (mv_valid),
        .o_in_bounds (mv_inb),
        .o_tgt_row   (mv_row),
        .o_tgt_col   (mv_col),
        .o_tgt_addr  (mv_addr)
    );

    assign tile = tile_t'(bus.i_rom_data);

    // Next-state and registered-output logic; pulses outside IDLE are simply not looked at.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tgt_row_d = tgt_row_q;
        tgt_col_d = tgt_col_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mv_valid) begin
                    if (mv_inb) begin
                        tgt_row_d = mv_row;
                        tgt_col_d = mv_col;
                        addr_d    = mv_addr;
                        state_d   = FETCH;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = CHECK;
            CHECK: begin
                if (tile == PATH || tile == EXIT) begin
                    row_d   = tgt_row_q;
                    col_d   = tgt_col_q;
                    moved_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + MOVE_CNT_W'(1);
                    if (tile == EXIT) begin
                        win_d   = 1'b1;
                        state_d = WON;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WON:     state_d = WON;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= START_R;
            col_q     <= START_C;
            tgt_row_q <= START_R;
            tgt_col_q <= START_C;
            addr_q    <= START_ADDR;
            cnt_q     <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
        end
    end

    assign bus.o_rom_addr   = addr_q;
    assign bus.o_row        = row_q;
    assign bus.o_col        = col_q;
    assign bus.o_moved      = moved_q;
    assign bus.o_blocked    = blocked_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_win        = win_q;
    assign bus.o_move_count = cnt_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: directed table, corner sequences and random moves against a tile-level model.
module tb_maze_player_ctrl;
    import maze_pkg::*;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int RBITS = 4;
    localparam int CBITS = 4;
    localparam int ABITS = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_player_ctrl_if #(.RBITS(RBITS), .CBITS(CBITS), .ABITS(ABITS)) bus ();

    maze_player_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .START_ROW(0), .START_COL(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [1:0] rom [ROWS*COLS];
    always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int m_row, m_col, m_cnt, m_addr;
    bit m_win;

    typedef struct {
        logic [3:0] p;
        bit         noise;
        bit         e_moved;
        bit         e_blocked;
        int         e_row;
        int         e_col;
        int         e_cnt;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_pulses(input logic [3:0] p);
        {bus.i_up, bus.i_down, bus.i_left, bus.i_right} = p;
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_cnt = 0; m_addr = 0; m_win = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row"},     32'(bus.o_row), 0);
        check({tag, "_col"},     32'(bus.o_col), 0);
        check({tag, "_addr"},    32'(bus.o_rom_addr), 0);
        check({tag, "_moved"},   32'(bus.o_moved), 0);
        check({tag, "_blocked"}, 32'(bus.o_blocked), 0);
        check({tag, "_busy"},    32'(bus.o_busy), 0);
        check({tag, "_win"},     32'(bus.o_win), 0);
        check({tag, "_count"},   32'(bus.o_move_count), 0);
    endtask

    task automatic do_reset();
        set_pulses(4'b0000);
        rst = 1'b0;
        #7;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Applies one pulse pattern, predicts the observable response from the tile rules and checks it.
    task automatic apply_move(input logic [3:0] p, input bit noise,
                              output int addr_seen, output bit got_moved, output bit got_blocked);
        int dr, dc, tr, tc, ta, exp_addr;
        bit has, inb, was_win, gate;
        logic [1:0] tile;
        logic [3:0] mv, bl, bz, emv, ebl, ebz;
        has = (p != 4'b0000);
        dr = 0; dc = 0;
        if (p[3])      dr = -1;
        else if (p[2]) dr = 1;
        else if (p[1]) dc = -1;
        else if (p[0]) dc = 1;
        tr = m_row + dr; tc = m_col + dc;
        inb = (tr >= 0) && (tr < ROWS) && (tc >= 0) && (tc < COLS);
        was_win = m_win;
        gate = noise && has && inb && !was_win;
        emv = '0; ebl = '0; ebz = '0; exp_addr = m_addr;
        if (was_win) begin
            ebz = 4'b1111;
        end else if (has && !inb) begin
            ebl[0] = 1'b1;
        end else if (has) begin
            ta = tr * COLS + tc;
            exp_addr = ta; m_addr = ta;
            tile = rom[ta];
            ebz[0] = 1'b1; ebz[1] = 1'b1;
            if (tile == 2'b00 || tile == 2'b10) begin
                emv[2] = 1'b1;
                m_row = tr; m_col = tc;
                m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
                if (tile == 2'b10) begin
                    m_win = 1'b1;
                    ebz[2] = 1'b1; ebz[3] = 1'b1;
                end
            end else begin
                ebl[2] = 1'b1;
            end
        end
        addr_seen = 0;
        @(negedge clk);
        set_pulses(p);
        for (int c = 0; c < 4; c++) begin
            if (c > 0 && c < 3 && gate) begin
                @(negedge clk);
                set_pulses(4'($urandom_range(1, 15)));
            end
            @(posedge clk);
            #1;
            set_pulses(4'b0000);
            mv[c] = bus.o_moved;
            bl[c] = bus.o_blocked;
            bz[c] = bus.o_busy;
            if (c == 0) addr_seen = int'(bus.o_rom_addr);
        end
        check("moved_seq",   32'(mv), 32'(emv));
        check("blocked_seq", 32'(bl), 32'(ebl));
        check("busy_seq",    32'(bz), 32'(ebz));
        check("rom_addr",    32'(addr_seen), 32'(exp_addr));
        check("row",         32'(bus.o_row), 32'(m_row));
        check("col",         32'(bus.o_col), 32'(m_col));
        check("count",       32'(bus.o_move_count), 32'(m_cnt));
        check("win",         32'(bus.o_win), 32'(m_win));
        got_moved   = |mv;
        got_blocked = |bl;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, cnt_before;
        bit gm, gb;
        vecs[0] = '{4'b0001, 1'b0, 1'b1, 1'b0, 0, 1, 1};
        vecs[1] = '{4'b0010, 1'b0, 1'b1, 1'b0, 0, 0, 2};
        vecs[2] = '{4'b1000, 1'b0, 1'b0, 1'b1, 0, 0, 2};
        vecs[3] = '{4'b0010, 1'b0, 1'b0, 1'b1, 0, 0, 2};
        vecs[4] = '{4'b0100, 1'b0, 1'b0, 1'b1, 0, 0, 2};
        vecs[5] = '{4'b0101, 1'b0, 1'b0, 1'b1, 0, 0, 2};
        vecs[6] = '{4'b0001, 1'b0, 1'b1, 1'b0, 0, 1, 3};
        vecs[7] = '{4'b0110, 1'b0, 1'b1, 1'b0, 1, 1, 4};
        vecs[8] = '{4'b0011, 1'b0, 1'b0, 1'b1, 1, 1, 4};
        vecs[9] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1, 2, 5};

        for (int i = 0; i < ROWS*COLS; i++) rom[i] = 2'b00;
        rom[1*COLS + 0] = 2'b01;
        set_pulses(4'b0000);
        model_reset();
        do_reset();

        for (int i = 0; i < 10; i++) begin
            apply_move(vecs[i].p, vecs[i].noise, a, gm, gb);
            check("vec_moved",   32'(gm), 32'(vecs[i].e_moved));
            check("vec_blocked", 32'(gb), 32'(vecs[i].e_blocked));
            check("vec_row",     32'(bus.o_row), 32'(vecs[i].e_row));
            check("vec_col",     32'(bus.o_col), 32'(vecs[i].e_col));
            check("vec_count",   32'(bus.o_move_count), 32'(vecs[i].e_cnt));
        end

        // Reserved tile code behaves as a wall.
        rom[2*COLS + 2] = 2'b11;
        apply_move(4'b0100, 1'b0, a, gm, gb);
        check("rsvd_blocked", 32'(gb), 1);
        check("rsvd_row", 32'(bus.o_row), 1);
        rom[2*COLS + 2] = 2'b00;

        // Walk to (5,5), then up+left together must request (4,5).
        while (m_row < 5) apply_move(4'b0100, 1'b0, a, gm, gb);
        while (m_col < 5) apply_move(4'b0001, 1'b0, a, gm, gb);
        apply_move(4'b1010, 1'b1, a, gm, gb);
        check("prio_addr", 32'(a), 69);
        check("prio_pos", 32'({bus.o_row, bus.o_col}), 32'({4'd4, 4'd5}));

        // Random walls and random pulse patterns.
        for (int i = 0; i < 30; i++)
            rom[$urandom_range(17, ROWS*COLS-1)] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
        for (int i = 0; i < 150; i++)
            apply_move(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a, gm, gb);

        // Exit tile: move counts, win latches, further pulses ignored.
        for (int i = 0; i < ROWS*COLS; i++) rom[i] = 2'b00;
        cnt_before = m_cnt;
        if (m_col < COLS-1) begin
            rom[m_row*COLS + m_col + 1] = 2'b10;
            apply_move(4'b0001, 1'b0, a, gm, gb);
        end else begin
            rom[m_row*COLS + m_col - 1] = 2'b10;
            apply_move(4'b0010, 1'b0, a, gm, gb);
        end
        check("win_set", 32'(bus.o_win), 1);
        check("win_count", 32'(bus.o_move_count), 32'(cnt_before + 1));
        for (int i = 0; i < 6; i++)
            apply_move(4'($urandom_range(1, 15)), 1'b0, a, gm, gb);
        do_reset();
        for (int i = 0; i < ROWS*COLS; i++) rom[i] = 2'b00;

        // Reset asserted mid-move discards the move.
        @(negedge clk);
        set_pulses(4'b0001);
        @(posedge clk);
        #1;
        set_pulses(4'b0000);
        check("abort_busy", 32'(bus.o_busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("abort_col_after", 32'(bus.o_col), 0);
        check("abort_moved_after", 32'(bus.o_moved), 0);

        // Saturate the move counter.
        while (m_cnt < 1023)
            apply_move((m_col == 0) ? 4'b0001 : 4'b0010, 1'b0, a, gm, gb);
        check("sat_count_reached", 32'(bus.o_move_count), 1023);
        apply_move((m_col == 0) ? 4'b0001 : 4'b0010, 1'b0, a, gm, gb);
        check("sat_moved", 32'(gm), 1);
        check("sat_count_hold", 32'(bus.o_move_count), 1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
